d_stage: RTL and testbench
==========================

Name: d_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline; the receiving end of the fetch interface.
- Latches `IR_F` and `pc4_F` into the F/D register.
- Decodes the instruction and produces the next-PC controls fed back to fetch: `pcsel`, `imm16`, `imm26`, `rs`, `equal`, `isbeq`, `stop`.
- Resolves operand forwarding from E/M, detects load-use and branch-use hazards, and inserts a bubble into E on stall.

Parameters:
- `NOP_WORD`, 32'h0000_0000, instruction word held in the F/D register after reset.
- `REG_W`, 5, register-address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `IR_F`  in  32  fetched instruction.
- `pc4_F`  in  32  fetch PC+4.
- `IR_E`  in  32  instruction currently in E.
- `IR_M`  in  32  instruction currently in M.
- `rd1`  in  32  register-file read data, port 1.
- `rd2`  in  32  register-file read data, port 2.
- `wdata_M`  in  32  M-stage result available for forwarding.
- `waddr_M`  in  5  M-stage destination register.
- `wen_M`  in  1  M-stage writes a register.
- `ra1`  out  5  register-file read address (rs field of `IR_D`).
- `ra2`  out  5  register-file read address (rt field of `IR_D`).
- `IR_D`  out  32  F/D-register instruction.
- `pc4_D`  out  32  F/D-register PC+4.
- `imm16`  out  16  `IR_D[15:0]`.
- `imm26`  out  26  `IR_D[25:0]`.
- `pcsel`  out  3  next-PC select: 0 = pc+4, 1 = branch, 2 = j/jal, 3 = jr.
- `isbeq`  out  1  `IR_D` is a conditional branch.
- `equal`  out  1  forwarded rs == forwarded rt.
- `rs`  out  32  forwarded rs value (jr target).
- `rt_fwd`  out  32  forwarded rt value, passed on to E.
- `stop`  out  1  stall: holds the PC and F/D.
- `bubble_E`  out  1  D/E register loads a nop next edge.

Behaviour:

Reset:
- On a rising `clk` with `reset` = 1: `IR_D` = `NOP_WORD`, `pc4_D` = 0.
- All other outputs are combinational from `IR_D`; therefore `pcsel` = 0, `isbeq` = 0, `stop` = 0, `bubble_E` = 0 the cycle after reset.
- Reset has priority over `stop`.

F/D register:
- `stop` = 0: `IR_D` and `pc4_D` load `IR_F` and `pc4_F` each edge.
- `stop` = 1: both hold.
- There is no flush; the branch delay slot always executes.

Decode (supported: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop):
- beq: `pcsel` = 1, `isbeq` = 1. Fetch decides taken/not-taken with `equal`.
- j and jal: `pcsel` = 2.
- jr: `pcsel` = 3.
- Anything else, including unknown opcodes: `pcsel` = 0, and the instruction is treated as a nop for hazard purposes.

Forwarding, per source operand (rs, rt), independently:
- Register 0 always reads 0.
- Else, if `wen_M` and `waddr_M` == source address: use `wdata_M`.
- Else: use the GRF read data.
- E-stage results are never forwarded into D; that case stalls instead.

Hazard (T_use / T_new):
- T_use = 0 for the beq operands and the jr rs operand.
- T_use = 1 for ALU, lw and sw address operands; the sw store-data operand (rt) has T_use = 2.
- T_new in E: lw = 2, ALU/lui/ori = 1, jal = 0.
- T_new in M: lw = 1, others = 0.
- `stop` = 1 when some source with a nonzero address matches a stage's destination and T_new(stage) > T_use.
- Destination register: rd for R-type, rt for I-type writers, 31 for jal.
- `bubble_E` = `stop`.

Boundary conditions:
- With E and M both matching the same register, the E hazard check decides.
- jal writing $31 while jr $31 is in D: stall until the result can be forwarded from M.

Optional Feature:
- Macro: `D_STAGE_BNE_EN`.
- Defined: bne (opcode 6'b000101) decodes with `pcsel` = 1 and `isbeq` = 0. Fetch takes the branch when `equal` = 0. Hazard handling is identical to beq.
- Undefined: bne is an unknown opcode and is treated as a nop.

Decomposition:
- Shared package `mips_defs`:
  - opcode and funct constants;
  - `pcsel` encodings (PC4, BR, J, JR);
  - T_new / T_use class constants;
  - a destination-register function.
- Sub-module `hazard_unit`: takes `IR_D`, `IR_E`, `IR_M` and returns `stop`.
- Forwarding muxes stay in `d_stage`.

Test Plan:
- Reset, then `IR_F` = 32'h3421_0005 (ori $1,$1,5), `pc4_F` = 32'h3004:
  - one edge after reset: `IR_D` = 0, `pcsel` = 0;
  - next edge: `IR_D` = 32'h3421_0005, `pc4_D` = 32'h3004.
- lw $2,0($0) in E, addu $3,$2,$2 in D → `stop` = 1 and `bubble_E` = 1 for one cycle; `IR_D` holds; then `stop` = 0.
- beq $1,$2 in D with `rd1` = 7, `rd2` = 9, `wen_M` = 1, `waddr_M` = 2, `wdata_M` = 7 → `equal` = 1, `pcsel` = 1, `isbeq` = 1, `stop` = 0.
- jr $31 in D, jal in E → `stop` = 1. Next cycle jal is in M with `wdata_M` = 32'h3010 → `rs` = 32'h3010, `pcsel` = 3, `stop` = 0.
- addu $0,$0,$0 in E, beq $0,$0 in D → `stop` = 0, `equal` = 1.
- With `D_STAGE_BNE_EN` defined, bne $1,$2 in D with `rd1` = 1, `rd2` = 2 → `pcsel` = 1, `isbeq` = 0, `equal` = 0. Without the macro, `pcsel` = 0.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS decode constants, hazard classes and helper functions
//
// Purpose: opcode/funct constants, next-PC select encodings, instruction
//          classes and the per-class T_use / T_new / destination rules used
//          by the decode stage and its hazard unit.
// Ports:   none (package).
// Config:  D_STAGE_BNE_EN - when defined, bne decodes as a conditional branch;
//          otherwise it is an unknown opcode and behaves as a nop.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;

   localparam logic [4:0] REG_RA   = 5'd31;

   typedef enum logic [2:0] {
      PCSEL_PC4 = 3'd0,
      PCSEL_BR  = 3'd1,
      PCSEL_J   = 3'd2,
      PCSEL_JR  = 3'd3
   } pcsel_e;

   typedef enum logic [3:0] {
      IC_NOP, IC_ALU_R, IC_ALU_I, IC_LUI, IC_LW, IC_SW,
      IC_BEQ, IC_BNE, IC_J, IC_JAL, IC_JR
   } iclass_e;

   // Cycles until a consumer needs (T_use) or a producer delivers (T_new) a value.
   localparam logic [1:0] T_0 = 2'd0;
   localparam logic [1:0] T_1 = 2'd1;
   localparam logic [1:0] T_2 = 2'd2;

   typedef struct packed {
      logic       used;
      logic [1:0] t_use;
   } src_use_t;

   function automatic iclass_e decode_class(input logic [31:0] ir);
      iclass_e c;
      c = IC_NOP;
      case (ir[31:26])
         OP_RTYPE: begin
            case (ir[5:0])
               FN_ADDU, FN_SUBU: c = IC_ALU_R;
               FN_JR:            c = IC_JR;
               default:          c = IC_NOP;
            endcase
         end
         OP_ORI:  c = IC_ALU_I;
         OP_LUI:  c = IC_LUI;
         OP_LW:   c = IC_LW;
         OP_SW:   c = IC_SW;
         OP_BEQ:  c = IC_BEQ;
`ifdef D_STAGE_BNE_EN
         OP_BNE:  c = IC_BNE;
`else
         OP_BNE:  c = IC_NOP;
`endif
         OP_J:    c = IC_J;
         OP_JAL:  c = IC_JAL;
         default: c = IC_NOP;
      endcase
      return c;
   endfunction

   function automatic pcsel_e pcsel_of(input iclass_e c);
      case (c)
         IC_BEQ, IC_BNE: return PCSEL_BR;
         IC_J, IC_JAL:   return PCSEL_J;
         IC_JR:          return PCSEL_JR;
         default:        return PCSEL_PC4;
      endcase
   endfunction

   function automatic src_use_t rs_use(input iclass_e c);
      case (c)
         IC_ALU_R, IC_ALU_I, IC_LW, IC_SW: return '{used: 1'b1, t_use: T_1};
         IC_BEQ, IC_BNE, IC_JR:            return '{used: 1'b1, t_use: T_0};
         default:                          return '{used: 1'b0, t_use: T_0};
      endcase
   endfunction

   function automatic src_use_t rt_use(input iclass_e c);
      case (c)
         IC_ALU_R:       return '{used: 1'b1, t_use: T_1};
         IC_SW:          return '{used: 1'b1, t_use: T_2};
         IC_BEQ, IC_BNE: return '{used: 1'b1, t_use: T_0};
         default:        return '{used: 1'b0, t_use: T_0};
      endcase
   endfunction

   function automatic logic [1:0] t_new_e(input iclass_e c);
      case (c)
         IC_LW:                      return T_2;
         IC_ALU_R, IC_ALU_I, IC_LUI: return T_1;
         default:                    return T_0;
      endcase
   endfunction

   function automatic logic [1:0] t_new_m(input iclass_e c);
      return (c == IC_LW) ? T_1 : T_0;
   endfunction

   // Non-writers report $0, which can never raise a hazard.
   function automatic logic [4:0] dest_reg(input logic [31:0] ir);
      case (decode_class(ir))
         IC_ALU_R:                 return ir[15:11];
         IC_ALU_I, IC_LUI, IC_LW:  return ir[20:16];
         IC_JAL:                   return REG_RA;
         default:                  return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/d_stage_hazard_unit.sv
// rtl/d_stage_hazard_unit.sv - load-use / branch-use stall detection for decode
//
// Purpose: compares the D-stage source operands against the E and M stage
//          destinations using T_use / T_new and raises stop.
// Ports:   ir_d, ir_e, ir_m (in, 32) - instructions in D, E, M
//          stop (out, 1)             - stall PC and F/D
// Config:  bne handling follows D_STAGE_BNE_EN through mips_defs.
module hazard_unit
   import mips_defs::*;
(
   input  logic [31:0] ir_d,
   input  logic [31:0] ir_e,
   input  logic [31:0] ir_m,
   output logic        stop
);

   iclass_e    cls_d, cls_e, cls_m;
   logic [4:0] dst_e, dst_m;
   logic [1:0] tn_e, tn_m;
   logic       stall_rs, stall_rt;

   // D has no forward path from E, so an operand needed in D right now
   // (T_use 0) stalls on any E producer, even one whose value is already
   // computed (jal's link address).
   function automatic logic src_stall(input logic [4:0] addr,  input src_use_t u,
                                      input logic [4:0] d_e,   input logic [1:0] t_e,
                                      input logic [4:0] d_m,   input logic [1:0] t_m);
      logic hit_e, hit_m;
      hit_e = (addr == d_e) && ((u.t_use == T_0) || (t_e > u.t_use));
      hit_m = (addr == d_m) && (t_m > u.t_use);
      return u.used && (addr != 5'd0) && (hit_e || hit_m);
   endfunction

   assign cls_d = decode_class(ir_d);
   assign cls_e = decode_class(ir_e);
   assign cls_m = decode_class(ir_m);
   assign dst_e = dest_reg(ir_e);
   assign dst_m = dest_reg(ir_m);
   assign tn_e  = t_new_e(cls_e);
   assign tn_m  = t_new_m(cls_m);

   assign stall_rs = src_stall(ir_d[25:21], rs_use(cls_d), dst_e, tn_e, dst_m, tn_m);
   assign stall_rt = src_stall(ir_d[20:16], rt_use(cls_d), dst_e, tn_e, dst_m, tn_m);
   assign stop     = stall_rs | stall_rt;

endmodule

// File: rtl/d_stage.sv
// rtl/d_stage.sv - MIPS decode stage: F/D register, next-PC decode, M forwarding, stall
//
// Purpose: holds the F/D register, decodes IR_D into next-PC controls for
//          fetch, forwards M-stage results onto rs/rt and stalls on hazards.
// Ports:   clk, reset (sync, active high)
//          IR_F, pc4_F          - fetch instruction / PC+4
//          IR_E, IR_M           - instructions in E and M (hazard checks)
//          rd1, rd2             - register-file read data
//          wdata_M, waddr_M, wen_M - M-stage write-back for forwarding
//          ra1, ra2             - register-file read addresses
//          IR_D, pc4_D          - F/D register contents
//          imm16, imm26, pcsel, isbeq, equal, rs - next-PC controls to fetch
//          rt_fwd               - forwarded rt towards E
//          stop, bubble_E       - stall and D/E bubble
// Config:  D_STAGE_BNE_EN - enables bne (pcsel branch, isbeq low).
module d_stage
   import mips_defs::*;
#(
   parameter logic [31:0] NOP_WORD = 32'h0000_0000,
   parameter int          REG_W    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      IR_F,
   input  logic [31:0]      pc4_F,
   input  logic [31:0]      IR_E,
   input  logic [31:0]      IR_M,
   input  logic [31:0]      rd1,
   input  logic [31:0]      rd2,
   input  logic [31:0]      wdata_M,
   input  logic [REG_W-1:0] waddr_M,
   input  logic             wen_M,
   output logic [REG_W-1:0] ra1,
   output logic [REG_W-1:0] ra2,
   output logic [31:0]      IR_D,
   output logic [31:0]      pc4_D,
   output logic [15:0]      imm16,
   output logic [25:0]      imm26,
   output logic [2:0]       pcsel,
   output logic             isbeq,
   output logic             equal,
   output logic [31:0]      rs,
   output logic [31:0]      rt_fwd,
   output logic             stop,
   output logic             bubble_E
);

   iclass_e cls_d;

   // No flush path: the delay slot always executes, so only stop gates the load.
   always_ff @(posedge clk) begin
      if (reset) begin
         IR_D  <= NOP_WORD;
         pc4_D <= 32'h0;
      end else if (!stop) begin
         IR_D  <= IR_F;
         pc4_D <= pc4_F;
      end
   end

   function automatic logic [31:0] fwd(input logic [REG_W-1:0] addr, input logic [31:0] grf,
                                       input logic wen, input logic [REG_W-1:0] waddr,
                                       input logic [31:0] wdata);
      if (addr == '0)
         return 32'h0;
      else if (wen && (waddr == addr))
         return wdata;
      else
         return grf;
   endfunction

   assign ra1    = IR_D[25:21];
   assign ra2    = IR_D[20:16];
   assign imm16  = IR_D[15:0];
   assign imm26  = IR_D[25:0];

   assign rs     = fwd(ra1, rd1, wen_M, waddr_M, wdata_M);
   assign rt_fwd = fwd(ra2, rd2, wen_M, waddr_M, wdata_M);
   assign equal  = (rs == rt_fwd);

   assign cls_d  = decode_class(IR_D);
   assign pcsel  = pcsel_of(cls_d);
   assign isbeq  = (cls_d == IC_BEQ);

   hazard_unit u_hazard (
      .ir_d (IR_D),
      .ir_e (IR_E),
      .ir_m (IR_M),
      .stop (stop)
   );

   assign bubble_E = stop;

endmodule

// File: tb/tb_d_stage.sv
// tb/tb_d_stage.sv - self-checking bench for d_stage (directed plus random)
module tb_d_stage;

   logic        clk;
   logic        reset;
   logic [31:0] IR_F, pc4_F, IR_E, IR_M, rd1, rd2, wdata_M;
   logic [4:0]  waddr_M;
   logic        wen_M;
   logic [4:0]  ra1, ra2;
   logic [31:0] IR_D, pc4_D, rs, rt_fwd;
   logic [15:0] imm16;
   logic [25:0] imm26;
   logic [2:0]  pcsel;
   logic        isbeq, equal, stop, bubble_E;

   d_stage dut (
      .clk(clk), .reset(reset), .IR_F(IR_F), .pc4_F(pc4_F), .IR_E(IR_E), .IR_M(IR_M),
      .rd1(rd1), .rd2(rd2), .wdata_M(wdata_M), .waddr_M(waddr_M), .wen_M(wen_M),
      .ra1(ra1), .ra2(ra2), .IR_D(IR_D), .pc4_D(pc4_D), .imm16(imm16), .imm26(imm26),
      .pcsel(pcsel), .isbeq(isbeq), .equal(equal), .rs(rs), .rt_fwd(rt_fwd),
      .stop(stop), .bubble_E(bubble_E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction kinds known to the bench:
   // 0 nop 1 addu 2 subu 3 ori 4 lui 5 lw 6 sw 7 beq 8 bne 9 j 10 jal 11 jr 12 unknown
   int tuse_rs [13];
   int tuse_rt [13];
   int tnew_e  [13];
   int tnew_m  [13];
   int dsel    [13];   // 0 none, 1 rd, 2 rt, 3 $31
   int pcsel_t [13];

   int kf, ke, km, kd;
   logic [31:0] exp_ir, exp_pc;
   int n_checks, n_err;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 4))
         0: return 5'd0;
         1: return 5'd1;
         2: return 5'd2;
         3: return 5'd3;
         default: return 5'd31;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr(input int k);
      logic [4:0]  s, t, d;
      logic [15:0] imm;
      logic [25:0] tgt;
      s = pick_reg(); t = pick_reg(); d = pick_reg();
      imm = 16'($urandom); tgt = 26'($urandom);
      case (k)
         0:  return 32'h0;
         1:  return {6'h00, s, t, d, 5'h00, 6'h21};
         2:  return {6'h00, s, t, d, 5'h00, 6'h23};
         3:  return {6'h0d, s, t, imm};
         4:  return {6'h0f, 5'd0, t, imm};
         5:  return {6'h23, s, t, imm};
         6:  return {6'h2b, s, t, imm};
         7:  return {6'h04, s, t, imm};
         8:  return {6'h05, s, t, imm};
         9:  return {6'h02, tgt};
         10: return {6'h03, tgt};
         11: return {6'h00, s, 15'd0, 6'h08};
         default: return {6'h3f, tgt};
      endcase
   endfunction

   function automatic int dest_of(input int k, input logic [31:0] w);
      case (dsel[k])
         1: return int'(w[15:11]);
         2: return int'(w[20:16]);
         3: return 31;
         default: return 0;
      endcase
   endfunction

   // An operand needed u cycles from now is late if its producer delivers
   // later than that; D only sees results through M, so a producer still in
   // E is always too late for an operand needed immediately.
   function automatic bit src_hazard(input int a, input int u);
      if (u < 0 || a == 0) return 1'b0;
      if (a == dest_of(ke, IR_E) && (u == 0 || tnew_e[ke] > u)) return 1'b1;
      if (a == dest_of(km, IR_M) && tnew_m[km] > u) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_stop();
      return src_hazard(int'(exp_ir[25:21]), tuse_rs[kd]) ||
             src_hazard(int'(exp_ir[20:16]), tuse_rt[kd]);
   endfunction

   function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] grf);
      if (a == 5'd0) return 32'h0;
      if (wen_M && waddr_M == a) return wdata_M;
      return grf;
   endfunction

   task automatic set_f(input int k, input logic [31:0] w); kf = k; IR_F = w; endtask
   task automatic set_e(input int k, input logic [31:0] w); ke = k; IR_E = w; endtask
   task automatic set_m(input int k, input logic [31:0] w); km = k; IR_M = w; endtask

   task automatic tick();
      bit s;
      s = model_stop();
      @(posedge clk);
      if (reset) begin
         kd = 0; exp_ir = 32'h0; exp_pc = 32'h0;
      end else if (!s) begin
         kd = kf; exp_ir = IR_F; exp_pc = pc4_F;
      end
      #1;
   endtask

   task automatic check_all();
      logic [31:0] ers, ert;
      bit es;
      ers = model_fwd(exp_ir[25:21], rd1);
      ert = model_fwd(exp_ir[20:16], rd2);
      es  = model_stop();
      check_eq("IR_D", IR_D, exp_ir);
      check_eq("pc4_D", pc4_D, exp_pc);
      check_eq("ra1", 32'(ra1), 32'(exp_ir[25:21]));
      check_eq("ra2", 32'(ra2), 32'(exp_ir[20:16]));
      check_eq("imm26", 32'(imm26), 32'(exp_ir[25:0]));
      check_eq("pcsel", 32'(pcsel), 32'(pcsel_t[kd]));
      check_eq("isbeq", 32'(isbeq), 32'(kd == 7));
      check_eq("rs", rs, ers);
      check_eq("rt_fwd", rt_fwd, ert);
      check_eq("equal", 32'(equal), 32'(ers == ert));
      check_eq("stop", 32'(stop), 32'(es));
      check_eq("bubble_E", 32'(bubble_E), 32'(es));
   endtask

   initial begin
      tuse_rs = '{-1, 1, 1, 1, -1, 1, 1, 0, -1, -1, -1, 0, -1};
      tuse_rt = '{-1, 1, 1, -1, -1, -1, 2, 0, -1, -1, -1, -1, -1};
      tnew_e  = '{0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0};
      tnew_m  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
      dsel    = '{0, 1, 1, 2, 2, 2, 0, 0, 0, 0, 3, 0, 0};
      pcsel_t = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 2, 3, 0};
`ifdef D_STAGE_BNE_EN
      tuse_rs[8] = 0; tuse_rt[8] = 0; pcsel_t[8] = 1;
`endif
      n_checks = 0; n_err = 0;
      kd = 0; exp_ir = 32'h0; exp_pc = 32'h0;
      rd1 = 0; rd2 = 0; wdata_M = 0; waddr_M = 0; wen_M = 0;
      set_e(0, 32'h0); set_m(0, 32'h0);

      // reset, then ori $1,$1,5 enters D
      reset = 1'b1;
      set_f(3, 32'h3421_0005); pc4_F = 32'h3004;
      tick();
      check_eq("rst_IR_D", IR_D, 32'h0);
      check_eq("rst_pcsel", 32'(pcsel), 32'd0);
      check_all();
      reset = 1'b0;
      tick();
      check_eq("ori_IR_D", IR_D, 32'h3421_0005);
      check_eq("ori_pc4_D", pc4_D, 32'h3004);
      check_all();

      // load-use: lw $2,0($0) in E, addu $3,$2,$2 in D
      set_f(1, {6'h00, 5'd2, 5'd2, 5'd3, 5'd0, 6'h21});
      tick();
      set_f(0, 32'h0);
      set_e(5, {6'h23, 5'd0, 5'd2, 16'h0});
      #1;
      check_eq("lu_stop", 32'(stop), 32'd1);
      check_eq("lu_bubble", 32'(bubble_E), 32'd1);
      check_all();
      tick();
      set_e(0, 32'h0); set_m(5, {6'h23, 5'd0, 5'd2, 16'h0});
      #1;
      check_eq("lu_hold", IR_D, {6'h00, 5'd2, 5'd2, 5'd3, 5'd0, 6'h21});
      check_eq("lu_release", 32'(stop), 32'd0);
      check_all();

      // beq $1,$2 with rt forwarded from M
      set_f(7, {6'h04, 5'd1, 5'd2, 16'h0010});
      tick();
      set_m(0, 32'h0);
      rd1 = 7; rd2 = 9; wen_M = 1; waddr_M = 2; wdata_M = 7;
      #1;
      check_eq("beq_equal", 32'(equal), 32'd1);
      check_eq("beq_pcsel", 32'(pcsel), 32'd1);
      check_eq("beq_isbeq", 32'(isbeq), 32'd1);
      check_eq("beq_stop", 32'(stop), 32'd0);
      check_all();

      // jr $31 behind jal
      set_f(11, {6'h00, 5'd31, 15'd0, 6'h08});
      tick();
      set_e(10, {6'h03, 26'h0000c04});
      wen_M = 0;
      #1;
      check_eq("jr_stop", 32'(stop), 32'd1);
      check_all();
      tick();
      set_e(0, 32'h0); set_m(10, {6'h03, 26'h0000c04});
      wen_M = 1; waddr_M = 31; wdata_M = 32'h3010;
      #1;
      check_eq("jr_rs", rs, 32'h3010);
      check_eq("jr_pcsel", 32'(pcsel), 32'd3);
      check_eq("jr_stop_rel", 32'(stop), 32'd0);
      check_all();

      // $0 never hazards and always reads zero
      set_f(7, {6'h04, 5'd0, 5'd0, 16'h0004});
      tick();
      set_e(1, {6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h21}); set_m(0, 32'h0);
      rd1 = 5; rd2 = 6; wen_M = 0;
      #1;
      check_eq("r0_stop", 32'(stop), 32'd0);
      check_eq("r0_equal", 32'(equal), 32'd1);
      check_all();

      // bne $1,$2
      set_f(8, {6'h05, 5'd1, 5'd2, 16'h0008});
      tick();
      set_e(0, 32'h0);
      rd1 = 1; rd2 = 2;
      #1;
`ifdef D_STAGE_BNE_EN
      check_eq("bne_pcsel", 32'(pcsel), 32'd1);
      check_eq("bne_isbeq", 32'(isbeq), 32'd0);
      check_eq("bne_equal", 32'(equal), 32'd0);
`else
      check_eq("bne_pcsel", 32'(pcsel), 32'd0);
`endif
      check_all();

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         int k;
         reset = ($urandom_range(0, 39) == 0);
         k = $urandom_range(0, 12); set_f(k, rand_instr(k));
         k = $urandom_range(0, 12); set_e(k, rand_instr(k));
         k = $urandom_range(0, 12); set_m(k, rand_instr(k));
         pc4_F   = $urandom;
         rd1     = $urandom;
         rd2     = ($urandom_range(0, 1) == 1) ? rd1 : $urandom;
         wdata_M = ($urandom_range(0, 1) == 1) ? rd1 : $urandom;
         waddr_M = pick_reg();
         wen_M   = 1'($urandom_range(0, 1));
         #1;
         check_all();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
